// File: rtl/tsall_ctrl.sv
// tsall_ctrl: synchronised global tristate controller with staggered per-bank release.
// Optional macro TSALL_CTRL_GLITCH_FILT_EN adds a FILT_LEN-cycle glitch filter after the synchroniser.
module tsall_ctrl #(
    parameter int NBANK       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int STAGGER     = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             TSALLN,
    input  logic [NBANK-1:0] BANK_MASK,
    output logic [NBANK-1:0] OE,
    output logic             TSALL_ACT,
    output logic             BUSY
);
    localparam logic [1:0] ST_HOLD    = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_ON      = 2'd2;
    localparam int PW = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;

    if ((NBANK < 1) || (NBANK > 32) || (SYNC_STAGES < 2) || (FILT_LEN < 1) || (STAGGER < 1)) begin : g_param_chk
        $error("tsall_ctrl: parameter out of range");
    end

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    logic                   filt_s;
    logic [1:0]             state_r;
    logic [1:0]             state_s;
    logic [PW-1:0]          ptr_r;
    logic [PW-1:0]          ptr_s;
    logic [SW-1:0]          scnt_r;
    logic [SW-1:0]          scnt_s;
    logic [NBANK-1:0]       oe_r;
    logic [NBANK-1:0]       oe_s;
    logic                   act_r;
    logic                   busy_r;

    // Synchroniser shift register; resets to the asserted (low) request level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], TSALLN};
        end
    end

    assign sync_s = sync_r[SYNC_STAGES-1];

`ifdef TSALL_CTRL_GLITCH_FILT_EN
    localparam int FW = $clog2(FILT_LEN) + 1;
    logic [FW-1:0] fcnt_r;
    logic          filt_r;

    // Glitch filter: level flips only after FILT_LEN consecutive differing samples.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fcnt_r <= {FW{1'b0}};
            filt_r <= 1'b0;
        end else if (sync_s == filt_r) begin
            fcnt_r <= {FW{1'b0}};
        end else if (fcnt_r == FW'(FILT_LEN - 1)) begin
            fcnt_r <= {FW{1'b0}};
            filt_r <= sync_s;
        end else begin
            fcnt_r <= fcnt_r + FW'(1'b1);
        end
    end

    assign filt_s = filt_r;
`else
    assign filt_s = sync_s;
`endif

    // Next-state logic: filt_s low means the tristate request is asserted.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        scnt_s  = scnt_r;
        oe_s    = oe_r;
        case (state_r)
            ST_HOLD: begin
                ptr_s  = {PW{1'b0}};
                scnt_s = {SW{1'b0}};
                if (filt_s) begin
                    state_s = ST_RELEASE;
                    oe_s    = ~BANK_MASK | NBANK'(1'b1);
                end else begin
                    oe_s    = ~BANK_MASK;
                end
            end
            ST_RELEASE: begin
                if (!filt_s) begin
                    state_s = ST_HOLD;
                    ptr_s   = {PW{1'b0}};
                    scnt_s  = {SW{1'b0}};
                    oe_s    = ~BANK_MASK;
                end else if (ptr_r == PW'(NBANK - 1)) begin
                    state_s = ST_ON;
                    ptr_s   = {PW{1'b0}};
                    scnt_s  = {SW{1'b0}};
                    oe_s    = {NBANK{1'b1}};
                end else if (scnt_r == SW'(STAGGER - 1)) begin
                    ptr_s   = ptr_r + PW'(1'b1);
                    scnt_s  = {SW{1'b0}};
                    oe_s    = oe_r | ~BANK_MASK | (NBANK'(1'b1) << (ptr_r + PW'(1'b1)));
                end else begin
                    scnt_s  = scnt_r + SW'(1'b1);
                    oe_s    = oe_r | ~BANK_MASK;
                end
            end
            ST_ON: begin
                if (!filt_s) begin
                    state_s = ST_HOLD;
                    oe_s    = ~BANK_MASK;
                end else begin
                    oe_s    = {NBANK{1'b1}};
                end
            end
            default: begin
                state_s = ST_HOLD;
                ptr_s   = {PW{1'b0}};
                scnt_s  = {SW{1'b0}};
                oe_s    = {NBANK{1'b0}};
            end
        endcase
    end

    // State, sequencing counters and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_HOLD;
            ptr_r   <= {PW{1'b0}};
            scnt_r  <= {SW{1'b0}};
            oe_r    <= {NBANK{1'b0}};
            act_r   <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            scnt_r  <= scnt_s;
            oe_r    <= oe_s;
            act_r   <= ~filt_s;
            busy_r  <= (state_s == ST_RELEASE);
        end
    end

    assign OE        = oe_r;
    assign TSALL_ACT = act_r;
    assign BUSY      = busy_r;

endmodule

// File: tb/tb_tsall_ctrl.sv
// Directed, table-driven bench for tsall_ctrl at default parameters.
// Expected latency follows the TSALL_CTRL_GLITCH_FILT_EN build setting.
module tb_tsall_ctrl;
`ifdef TSALL_CTRL_GLITCH_FILT_EN
    localparam int L = 7;
`else
    localparam int L = 3;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic       TSALLN;
    logic [3:0] BANK_MASK;
    logic [3:0] OE;
    logic       TSALL_ACT;
    logic       BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic       tsalln;
        logic [3:0] mask;
        int         n;
        logic [3:0] oe;
        logic       act;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    tsall_ctrl #(
        .NBANK(4), .SYNC_STAGES(2), .FILT_LEN(4), .STAGGER(8)
    ) dut (
        .CLK(CLK), .RST(RST), .TSALLN(TSALLN), .BANK_MASK(BANK_MASK),
        .OE(OE), .TSALL_ACT(TSALL_ACT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic void add(string nm, logic r, logic t, logic [3:0] m, int n,
                                logic [3:0] oe, logic a, logic b);
        vec_t v;
        v.name = nm; v.rst = r; v.tsalln = t; v.mask = m; v.n = n;
        v.oe = oe; v.act = a; v.busy = b;
        vecs.push_back(v);
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(string nm, logic [3:0] oe_e, logic act_e, logic busy_e);
        n_checks++;
        if (OE !== oe_e) begin
            n_fail++;
            $display("FAIL %s OE: got %b expected %b", nm, OE, oe_e);
        end
        n_checks++;
        if (TSALL_ACT !== act_e) begin
            n_fail++;
            $display("FAIL %s TSALL_ACT: got %b expected %b", nm, TSALL_ACT, act_e);
        end
        n_checks++;
        if (BUSY !== busy_e) begin
            n_fail++;
            $display("FAIL %s BUSY: got %b expected %b", nm, BUSY, busy_e);
        end
    endtask

    initial begin
        // name, rst, tsalln, mask, edges to advance, expected OE, TSALL_ACT, BUSY
        add("reset",        1'b1, 1'b1, 4'hF, 2,     4'h0, 1'b1, 1'b0);
        add("hold_pre",     1'b0, 1'b1, 4'hF, L - 1, 4'h0, 1'b1, 1'b0);
        add("rel_oe0",      1'b0, 1'b1, 4'hF, 1,     4'h1, 1'b0, 1'b1);
        add("rel_oe0_hold", 1'b0, 1'b1, 4'hF, 7,     4'h1, 1'b0, 1'b1);
        add("rel_oe1",      1'b0, 1'b1, 4'hF, 1,     4'h3, 1'b0, 1'b1);
        add("rel_oe2",      1'b0, 1'b1, 4'hF, 8,     4'h7, 1'b0, 1'b1);
        add("rel_oe2_hold", 1'b0, 1'b1, 4'hF, 7,     4'h7, 1'b0, 1'b1);
        add("rel_oe3",      1'b0, 1'b1, 4'hF, 1,     4'hF, 1'b0, 1'b1);
        add("on",           1'b0, 1'b1, 4'hF, 1,     4'hF, 1'b0, 1'b0);
        add("on_mask_ign",  1'b0, 1'b1, 4'h0, 3,     4'hF, 1'b0, 1'b0);
        add("assert_pre",   1'b0, 1'b0, 4'hF, L - 1, 4'hF, 1'b0, 1'b0);
        add("assert",       1'b0, 1'b0, 4'hF, 1,     4'h0, 1'b1, 1'b0);
        add("hold_mask",    1'b0, 1'b0, 4'h5, 1,     4'hA, 1'b1, 1'b0);
        add("m_rel_pre",    1'b0, 1'b1, 4'h5, L - 1, 4'hA, 1'b1, 1'b0);
        add("m_rel_oe0",    1'b0, 1'b1, 4'h5, 1,     4'hB, 1'b0, 1'b1);
        add("m_rel_idx1",   1'b0, 1'b1, 4'h5, 8,     4'hB, 1'b0, 1'b1);
        add("m_rel_oe2",    1'b0, 1'b1, 4'h5, 8,     4'hF, 1'b0, 1'b1);
        add("m_rel_idx3",   1'b0, 1'b1, 4'h5, 8,     4'hF, 1'b0, 1'b1);
        add("m_on",         1'b0, 1'b1, 4'h5, 1,     4'hF, 1'b0, 1'b0);
        add("hold2",        1'b0, 1'b0, 4'hF, L,     4'h0, 1'b1, 1'b0);
        add("rel2_oe1",     1'b0, 1'b1, 4'hF, L + 8, 4'h3, 1'b0, 1'b1);
        add("abort_pre",    1'b0, 1'b0, 4'hF, L - 1, 4'h3, 1'b0, 1'b1);
        add("abort",        1'b0, 1'b0, 4'hF, 1,     4'h0, 1'b1, 1'b0);
        add("restart_oe0",  1'b0, 1'b1, 4'hF, L,     4'h1, 1'b0, 1'b1);
        add("restart_oe1",  1'b0, 1'b1, 4'hF, 8,     4'h3, 1'b0, 1'b1);
        add("pre_rst",      1'b0, 1'b1, 4'hF, 5,     4'h3, 1'b0, 1'b1);
        add("mid_rst",      1'b1, 1'b1, 4'hF, 1,     4'h0, 1'b1, 1'b0);
        add("rst_pre",      1'b0, 1'b1, 4'hF, L - 1, 4'h0, 1'b1, 1'b0);
        add("rst_oe0",      1'b0, 1'b1, 4'hF, 1,     4'h1, 1'b0, 1'b1);
        add("rel_unmask",   1'b0, 1'b1, 4'hB, 1,     4'h5, 1'b0, 1'b1);
        add("rel_remask",   1'b0, 1'b1, 4'hF, 1,     4'h5, 1'b0, 1'b1);
        add("rel3_oe1",     1'b0, 1'b1, 4'hF, 6,     4'h7, 1'b0, 1'b1);
        add("rel3_oe3",     1'b0, 1'b1, 4'hF, 16,    4'hF, 1'b0, 1'b1);
        add("on3",          1'b0, 1'b1, 4'hF, 1,     4'hF, 1'b0, 1'b0);

        RST       = 1'b1;
        TSALLN    = 1'b1;
        BANK_MASK = 4'hF;

        foreach (vecs[i]) begin
            RST       = vecs[i].rst;
            TSALLN    = vecs[i].tsalln;
            BANK_MASK = vecs[i].mask;
            step(vecs[i].n);
            check(vecs[i].name, vecs[i].oe, vecs[i].act, vecs[i].busy);
        end

`ifdef TSALL_CTRL_GLITCH_FILT_EN
        // Three-cycle low pulse from ON must be swallowed by the filter.
        TSALLN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("glitch_low", 4'hF, 1'b0, 1'b0);
        end
        TSALLN = 1'b1;
        for (int i = 0; i < L + 4; i++) begin
            step(1);
            check("glitch_after", 4'hF, 1'b0, 1'b0);
        end
`else
        // Single-cycle low pulse from ON is acted on without a filter.
        TSALLN = 1'b0;
        step(1);
        check("pulse_e1", 4'hF, 1'b0, 1'b0);
        TSALLN = 1'b1;
        step(1);
        check("pulse_e2", 4'hF, 1'b0, 1'b0);
        step(1);
        check("pulse_e3", 4'h0, 1'b1, 1'b0);
        step(1);
        check("pulse_rel_oe0", 4'h1, 1'b0, 1'b1);
        step(8);
        check("pulse_rel_oe1", 4'h3, 1'b0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
